// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one 8-bit SPI master core among NREQ requesters,
// owning the slave selects, CS setup/hold spacing and the per-byte start/irq/ack handshake.
module spi_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_i,
  output logic [NREQ-1:0]        gnt_o,
  input  logic [NREQ*DATA_W-1:0] tx_i,
  input  logic [NREQ-1:0]        tx_valid_i,
  input  logic [NREQ-1:0]        tx_last_i,
  output logic [NREQ-1:0]        tx_ready_o,
  output logic [DATA_W-1:0]      rx_o,
  output logic [NREQ-1:0]        rx_valid_o,
  output logic [NREQ-1:0]        ss_n_o,
  output logic                   spi_start_o,
  output logic [DATA_W-1:0]      spi_tx_o,
  input  logic [DATA_W-1:0]      spi_rx_i,
  input  logic                   spi_busy_i,
  input  logic                   spi_irq_i,
  output logic                   spi_ack_o
);
  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_XFER, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]       gidx_q, gidx_d, rr_q, rr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                last_q, last_d, start_q, start_d, ack_q, ack_d;
  logic [DATA_W-1:0]   stx_q, stx_d, rx_q, rx_d;
  logic [NREQ-1:0]     rxv_q, rxv_d;

  logic                win_found;
  logic [IW-1:0]       win_idx;
  int                  win_k;
  logic [DATA_W-1:0]   tx_sel;
  logic                txv_sel, txl_sel, req_sel;

  assign tx_sel  = tx_i[gidx_q*DATA_W +: DATA_W];
  assign txv_sel = tx_valid_i[gidx_q];
  assign txl_sel = tx_last_i[gidx_q];
  assign req_sel = req_i[gidx_q];

  // Rotating-priority scan: first requester at or after rr_q wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      win_k = int'(rr_q) + i;
      if (win_k >= NREQ) win_k = win_k - NREQ;
      if (!win_found && req_i[win_k]) begin
        win_found = 1'b1;
        win_idx   = IW'(win_k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    stx_d   = stx_q;
    rx_d    = rx_q;
    start_d = 1'b0;
    ack_d   = 1'b0;
    rxv_d   = '0;
    case (state_q)
      S_IDLE: if (win_found) begin
        gnt_d          = '0;
        gnt_d[win_idx] = 1'b1;
        gidx_d         = win_idx;
        cnt_d          = CW'(CS_SETUP - 1);
        state_d        = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == '0) state_d = S_LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_LOAD: begin
        if (txv_sel && !spi_busy_i) begin
          stx_d   = tx_sel;
          last_d  = txl_sel;
          start_d = 1'b1;
          state_d = S_XFER;
        end else if (!req_sel) begin
          cnt_d   = CW'(CS_HOLD - 1);
          state_d = S_HOLD;
        end
      end
      S_XFER: begin
        // The irq flag may still be the previous byte's during the start cycle.
        if (spi_irq_i && !start_q) begin
          rx_d  = spi_rx_i;
          rxv_d = gnt_q;
          ack_d = 1'b1;
          if (last_q || !req_sel) begin
            cnt_d   = CW'(CS_HOLD - 1);
            state_d = S_HOLD;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          gnt_d   = '0;
          rr_d    = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      stx_q   <= '0;
      rx_q    <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      rxv_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      stx_q   <= stx_d;
      rx_q    <= rx_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      rxv_q   <= rxv_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign ss_n_o      = ~gnt_q;
  assign tx_ready_o  = (state_q == S_LOAD && !spi_busy_i) ? gnt_q : '0;
  assign rx_o        = rx_q;
  assign rx_valid_o  = rxv_q;
  assign spi_start_o = start_q;
  assign spi_tx_o    = stx_q;
  assign spi_ack_o   = ack_q;
endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master core (8-bit `SPI_Master`, same clock domain) among `NREQ` requesters. It owns per-requester slave selects, enforces CS setup/hold spacing, and moves multi-byte bursts between the granted requester and the core's start/busy/irq/ack handshake. It sits between on-chip peripherals (flash loader, ADC poller, CPU SPI port) and the single SPI pin set.

## Interface

Parameters:
- `NREQ`, 2, number of requesters, 2..4.
- `DATA_W`, 8, SPI word width.
- `CS_SETUP`, 2, cycles from ss_n low to first start, ≥1.
- `CS_HOLD`, 2, cycles from last irq ack to ss_n high, ≥1.

Ports:
- `clk_i`  in  1  system clock, also clocks the SPI core.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  NREQ  requester wants the bus; held high for whole burst.
- `gnt_o`  out  NREQ  one-hot grant, registered.
- `tx_i`  in  NREQ*DATA_W  per-requester TX byte, requester k at `[k*DATA_W +: DATA_W]`.
- `tx_valid_i`  in  NREQ  TX byte valid.
- `tx_last_i`  in  NREQ  byte is last of burst, sampled with valid.
- `tx_ready_o`  out  NREQ  arbiter accepts byte (combinational from state and grant).
- `rx_o`  out  DATA_W  received byte, shared, registered.
- `rx_valid_o`  out  NREQ  one-cycle strobe to granted requester.
- `ss_n_o`  out  NREQ  active-low slave selects.
- `spi_start_o`  out  1  one-cycle start pulse to core.
- `spi_tx_o`  out  DATA_W  byte to core, stable from start until irq.
- `spi_rx_i`  in  DATA_W  core RX data.
- `spi_busy_i`  in  1  core busy.
- `spi_irq_i`  in  1  core byte-done flag, level until acked.
- `spi_ack_o`  out  1  one-cycle flag clear to core.

## Operation

- States: IDLE, SETUP, LOAD, XFER, HOLD.
- IDLE: all ss_n high, gnt 0. If any `req_i`, grant the first set bit scanning from `rr_ptr` upward (mod NREQ); gnt_o/ss_n_o of winner take effect next edge; load counter with CS_SETUP-1; go SETUP.
- SETUP: count down; at 0 go LOAD.
- LOAD: `tx_ready_o[g]` = 1 when `spi_busy_i`=0. On valid&ready: register `spi_tx_o`<=byte, `last_r`<=tx_last_i, `spi_start_o`=1 next cycle, go XFER. If `req_i[g]`=0 in LOAD (no handshake that cycle), go HOLD.
- XFER: wait `spi_irq_i`. On irq: `rx_o`<=`spi_rx_i`, `rx_valid_o[g]`=1 and `spi_ack_o`=1 for exactly one cycle; then HOLD if `last_r` or `req_i[g]`=0, else LOAD. Irq ignored during the start-pulse cycle.
- HOLD: count CS_HOLD cycles with ss_n still low; then ss_n high, gnt 0, `rr_ptr`<=g+1 mod NREQ, IDLE.
- Request drop during XFER: current byte completes and is delivered; no further bytes.
- Non-granted requesters: tx_ready_o and rx_valid_o held 0; their tx_valid_i ignored.
- Reset (asynchronous, any state incl. mid-byte): state IDLE, rr_ptr 0, gnt_o 0, ss_n_o all 1, tx_ready_o 0, rx_valid_o 0, rx_o 0, spi_tx_o 0, spi_start_o 0, spi_ack_o 0, last_r 0.

## Timing

- req_i rising sampled at edge N → gnt_o/ss_n_o low at N+1; tx_ready_o high at N+1+CS_SETUP.
- Handshake at edge M → spi_start_o high cycle M..M+1 only, XFER from M+1.
- irq seen at edge K → rx_o, rx_valid_o, spi_ack_o valid K+1 for one cycle; next tx_ready_o earliest K+1 (if not last).
- Last irq at K → ss_n high at K+1+CS_HOLD; IDLE for ≥1 cycle before next grant (all ss_n high ≥1 cycle between bursts).
- Ports never see two grants at once; gnt_o and ss_n_o always complementary for the granted bit.

## Test plan

- Reset mid-XFER with ss_n_o=2'b10 → ss_n_o=2'b11, gnt_o=0, spi_start_o=0 immediately, no rx_valid after release.
- NREQ=2, req_i=2'b01, 3 bytes 0xA5,0x3C,0xFF (last on 3rd), core loops tx→rx → three rx_valid_o[0] pulses with 0xA5,0x3C,0xFF; ss_n_o[0] low from edge 1 to 2+CS_HOLD cycles after 3rd irq.
- req_i=2'b11 held through two bursts → grants 0 then 1 then 0 (round-robin), ≥1 cycle ss_n_o=2'b11 between.
- spi_busy_i forced high in LOAD for 5 cycles → tx_ready_o low, no start until busy drops.
- req_i[1] dropped during XFER of byte 2 of 4 → byte 2 delivered, no 3rd start, HOLD then IDLE.
- tx_valid_i[1] asserted while gnt_o=2'b01 → tx_ready_o[1]=0, spi_tx_o unchanged.
